// File: rtl/preg_alloc_ctrl.sv
// rtl/preg_alloc_ctrl.sv - rename grant, free-register accounting and ROB rollback/walk sequencing
// Optional build macro PREG_ALLOC_RESERVE_EN holds two registers back from rename grants.
module preg_alloc_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rn0_req,
  input  logic                 rn1_req,
  output logic                 rn_ready,
  output logic                 alloc0_valid,
  output logic                 alloc1_valid,
  input  logic                 commit0_free,
  input  logic                 commit1_free,
  input  logic                 flush_valid,
  input  logic [CNT_WIDTH-1:0] flush_walk_num,
  output logic [1:0]           rob_state,
  output logic                 walk0_valid,
  output logic                 walk1_valid,
  output logic [CNT_WIDTH-1:0] free_count,
  output logic                 recover_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ROLLBACK = 2'b01,
    ST_WALK     = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH:0] NUM_REGS_W = (CNT_WIDTH+1)'(NUM_REGS);
`ifdef PREG_ALLOC_RESERVE_EN
  localparam logic [CNT_WIDTH:0] RESERVE = (CNT_WIDTH+1)'(2);
`else
  localparam logic [CNT_WIDTH:0] RESERVE = '0;
`endif

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] free_cnt_q;
  logic                 overflow_err;

  logic [1:0]           req_num;
  logic [1:0]           commit_cnt;
  logic [1:0]           walk_cnt;
  logic [1:0]           alloc_cnt;
  logic [CNT_WIDTH:0]   need;
  logic [CNT_WIDTH:0]   fc_sum;
  logic [CNT_WIDTH-1:0] remaining_next;
  logic                 idle_open;
  logic                 walk_en;

  // rn1_req alone is ignored: slot 1 can only be granted alongside slot 0
  assign req_num    = {rn0_req & rn1_req, rn0_req & ~rn1_req};
  assign need       = (CNT_WIDTH+1)'(req_num) + RESERVE;
  assign idle_open  = !reset && (state == ST_IDLE) && !flush_valid;
  assign walk_en    = !reset && (state == ST_WALK) && !flush_valid;

  assign rn_ready     = idle_open && (need <= {1'b0, free_cnt_q});
  assign alloc0_valid = rn0_req && rn_ready;
  assign alloc1_valid = rn0_req && rn1_req && rn_ready;

  assign walk0_valid  = walk_en && (remaining != '0);
  assign walk1_valid  = walk_en && (remaining >= CNT_WIDTH'(2));

  assign commit_cnt = {1'b0, commit0_free} + {1'b0, commit1_free};
  assign walk_cnt   = {walk1_valid, walk0_valid & ~walk1_valid};
  assign alloc_cnt  = {alloc1_valid, alloc0_valid & ~alloc1_valid};

  // Grants never exceed free_cnt_q, so the subtraction cannot wrap
  assign fc_sum = {1'b0, free_cnt_q} + (CNT_WIDTH+1)'(commit_cnt)
                + (CNT_WIDTH+1)'(walk_cnt) - (CNT_WIDTH+1)'(alloc_cnt);
  assign remaining_next = remaining - CNT_WIDTH'(walk_cnt);

  assign rob_state    = state;
  assign free_count   = free_cnt_q;
  assign recover_busy = (state != ST_IDLE) || flush_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      free_cnt_q   <= CNT_WIDTH'(NUM_REGS);
      overflow_err <= 1'b0;
    end else begin
      if (fc_sum > NUM_REGS_W) begin
        free_cnt_q   <= CNT_WIDTH'(NUM_REGS);
        overflow_err <= 1'b1;
      end else begin
        free_cnt_q <= fc_sum[CNT_WIDTH-1:0];
      end

      if (flush_valid) begin
        state     <= ST_ROLLBACK;
        remaining <= flush_walk_num;
      end else begin
        case (state)
          ST_ROLLBACK: state <= (remaining != '0) ? ST_WALK : ST_IDLE;
          ST_WALK: begin
            remaining <= remaining_next;
            if (remaining_next == '0) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// tb/tb_preg_alloc_ctrl.sv - directed scenarios plus randomized traffic against a queue-free count model
module tb_preg_alloc_ctrl;

  localparam int NREG = 32;
`ifdef PREG_ALLOC_RESERVE_EN
  localparam int RSV = 2;
`else
  localparam int RSV = 0;
`endif

  logic       clock;
  logic       reset;
  logic       rn0_req, rn1_req;
  logic       rn_ready, alloc0_valid, alloc1_valid;
  logic       commit0_free, commit1_free;
  logic       flush_valid;
  logic [5:0] flush_walk_num;
  logic [1:0] rob_state;
  logic       walk0_valid, walk1_valid;
  logic [5:0] free_count;
  logic       recover_busy;

  preg_alloc_ctrl #(.NUM_REGS(NREG), .CNT_WIDTH(6)) dut (
    .clock(clock), .reset(reset),
    .rn0_req(rn0_req), .rn1_req(rn1_req), .rn_ready(rn_ready),
    .alloc0_valid(alloc0_valid), .alloc1_valid(alloc1_valid),
    .commit0_free(commit0_free), .commit1_free(commit1_free),
    .flush_valid(flush_valid), .flush_walk_num(flush_walk_num),
    .rob_state(rob_state), .walk0_valid(walk0_valid), .walk1_valid(walk1_valid),
    .free_count(free_count), .recover_busy(recover_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 rollback, 2 walk
  int m_state, m_rem, m_fc;
  bit m_ovf;
  int last_walk, last_ready, grants;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_fc = NREG; m_ovf = 1'b0;
  endtask

  task automatic do_cycle(input bit r, input bit a, input bit b, input bit c0,
                          input bit c1, input bit fl, input int wn);
    int req_num, w, al, sum;
    bit ex_ready;
    @(negedge clock);
    reset = r; rn0_req = a; rn1_req = b; commit0_free = c0; commit1_free = c1;
    flush_valid = fl; flush_walk_num = 6'(wn);
    #1;
    req_num  = a ? 1 + int'(b) : 0;
    ex_ready = !r && m_state == 0 && !fl && (req_num + RSV <= m_fc);
    w        = (!r && m_state == 2 && !fl) ? ((m_rem >= 2) ? 2 : m_rem) : 0;
    al       = ex_ready ? req_num : 0;
    check_val("rn_ready", 32'(rn_ready), 32'(ex_ready));
    check_val("alloc0", 32'(alloc0_valid), 32'(al >= 1));
    check_val("alloc1", 32'(alloc1_valid), 32'(al == 2));
    check_val("walk0", 32'(walk0_valid), 32'(w >= 1));
    check_val("walk1", 32'(walk1_valid), 32'(w == 2));
    check_val("rob_state", 32'(rob_state), 32'(m_state));
    check_val("free_count", 32'(free_count), 32'(m_fc));
    check_val("recover_busy", 32'(recover_busy), 32'(m_state != 0 || fl));
    check_val("overflow_err", 32'(dut.overflow_err), 32'(m_ovf));
    last_walk  = int'(walk0_valid) + int'(walk1_valid);
    last_ready = int'(rn_ready);
    if (r) begin
      model_reset();
    end else begin
      sum = m_fc + int'(c0) + int'(c1) + w - al;
      if (sum > NREG) begin
        m_fc = NREG; m_ovf = 1'b1;
      end else begin
        m_fc = sum;
      end
      if (fl) begin
        m_state = 1; m_rem = wn;
      end else if (m_state == 1) begin
        m_state = (m_rem != 0) ? 2 : 0;
      end else if (m_state == 2) begin
        m_rem -= w;
        if (m_rem == 0) m_state = 0;
      end
    end
  endtask

  task automatic post_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    do_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  int beats;

  initial begin
    reset = 1'b1; rn0_req = 0; rn1_req = 0; commit0_free = 0; commit1_free = 0;
    flush_valid = 0; flush_walk_num = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_rn_ready", 32'(rn_ready), 32'd0);
    model_reset();
    do_cycle(1, 1, 1, 0, 0, 0, 0);
    post_edge();
    check_val("reset_fc", 32'(free_count), 32'd32);
    check_val("reset_state", 32'(rob_state), 32'd0);
    check_val("reset_ovf", 32'(dut.overflow_err), 32'd0);

`ifndef PREG_ALLOC_RESERVE_EN
    // drain with dual requests
    grants = 0;
    for (int i = 0; i < 16; i++) begin
      do_cycle(0, 1, 1, 0, 0, 0, 0);
      grants += last_ready;
    end
    post_edge();
    check_val("drain_grants", 32'(grants), 32'd16);
    check_val("drain_fc", 32'(free_count), 32'd0);
    do_cycle(0, 1, 1, 0, 0, 0, 0);
    check_val("empty_ready", 32'(last_ready), 32'd0);

    do_cycle(0, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 1, 1, 0, 0, 0, 0);
    check_val("fc1_dual_ready", 32'(last_ready), 32'd0);
    do_cycle(0, 1, 0, 0, 0, 0, 0);
    check_val("fc1_single_ready", 32'(last_ready), 32'd1);
    post_edge();
    check_val("fc1_after", 32'(free_count), 32'd0);

    // flush of length 5: rollback, beats 2,2,1
    do_cycle(0, 1, 1, 0, 0, 1, 5);
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 1, 1, 0, 0, 0, 0);
      beats = beats * 4 + last_walk;
      check_val("walk_ready_low", 32'(last_ready), 32'd0);
    end
    post_edge();
    check_val("walk5_beats", 32'(beats), 32'd41);
    check_val("walk5_fc", 32'(free_count), 32'd5);
    check_val("walk5_state", 32'(rob_state), 32'd0);

    // restart while walking with remaining=3
    do_cycle(0, 0, 0, 0, 0, 1, 5);
    idle_cycle();
    idle_cycle();
    do_cycle(0, 0, 0, 0, 0, 1, 2);
    check_val("restart_no_walk", 32'(last_walk), 32'd0);
    post_edge();
    check_val("restart_rollback", 32'(rob_state), 32'd1);
    idle_cycle();
    idle_cycle();
    check_val("restart_dual_beat", 32'(last_walk), 32'd2);
    post_edge();
    check_val("restart_state", 32'(rob_state), 32'd0);
    check_val("restart_fc", 32'(free_count), 32'd9);
`endif

`ifdef PREG_ALLOC_RESERVE_EN
    for (int i = 0; i < 15; i++) do_cycle(0, 1, 1, 0, 0, 0, 0);
    post_edge();
    check_val("rsv_drain_fc", 32'(free_count), 32'd2);
    do_cycle(0, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 1, 1, 0, 0, 0, 0);
    check_val("rsv_dual_ready", 32'(last_ready), 32'd0);
    do_cycle(0, 1, 0, 0, 0, 0, 0);
    check_val("rsv_single_ready", 32'(last_ready), 32'd1);
    post_edge();
    check_val("rsv_fc_after", 32'(free_count), 32'd2);
`endif

    // zero-length flush with a commit in the same cycle
    beats = m_fc;
    do_cycle(0, 0, 0, 1, 0, 1, 0);
    post_edge();
    check_val("zero_flush_rb", 32'(rob_state), 32'd1);
    idle_cycle();
    post_edge();
    check_val("zero_flush_idle", 32'(rob_state), 32'd0);
    check_val("zero_flush_fc", 32'(free_count), 32'(beats + 1));

    // reset in the middle of a walk
    do_cycle(0, 0, 0, 0, 0, 1, 10);
    idle_cycle();
    idle_cycle();
    do_cycle(1, 0, 0, 0, 0, 0, 0);
    check_val("reset_walk_strobe", 32'(last_walk), 32'd0);
    post_edge();
    check_val("reset_walk_state", 32'(rob_state), 32'd0);
    check_val("reset_walk_fc", 32'(free_count), 32'd32);

    // commit while full saturates and sets the sticky flag
    do_cycle(0, 0, 0, 1, 1, 0, 0);
    post_edge();
    check_val("ovf_fc", 32'(free_count), 32'd32);
    check_val("ovf_flag", 32'(dut.overflow_err), 32'd1);
    do_cycle(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      do_cycle($urandom_range(0, 299) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 19) == 0,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                           : int'($urandom_range(0, 9)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
